// File: rtl/pushbutton_alu_responder_if.sv
// Board-side bundle for the pushbutton ALU responder: raw buttons and operand
// switches in, registered result and status out.
interface pushbutton_alu_responder_if #(
    parameter int WIDTH = 4
);
    logic             pushbutton_one;
    logic             pushbutton_two;
    logic             pushbutton_three;
    logic             pushbutton_four;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] result;
    logic [1:0]       op_code;
    logic             result_valid;
    logic             busy;

    modport master (
        output pushbutton_one, pushbutton_two, pushbutton_three, pushbutton_four,
        output A, B,
        input  result, op_code, result_valid, busy
    );

    modport slave (
        input  pushbutton_one, pushbutton_two, pushbutton_three, pushbutton_four,
        input  A, B,
        output result, op_code, result_valid, busy
    );
endinterface

// File: rtl/pushbutton_alu_responder.sv
// Debounces four pushbuttons, captures A/B on the highest-priority press and
// holds the selected ADD/SUB/AND/OR result until the next operation.
module pushbutton_alu_responder #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic                      clk,
    input logic                      reset,
    pushbutton_alu_responder_if.slave bus
);

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    logic [3:0]       rawBtn;
    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [3:0]       level_q;
    logic [3:0]       levelPrev_q;
    logic [7:0]       cnt_q [4];
    logic [3:0]       press;
    logic             anyPress;
    logic [1:0]       pressOp;

    state_t           state_q;
    logic [WIDTH-1:0] capA_q;
    logic [WIDTH-1:0] capB_q;
    logic [1:0]       capOp_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;
    logic [1:0]       opCode_q;
    logic             valid_q;
    logic             busy_q;

    assign rawBtn = {bus.pushbutton_four, bus.pushbutton_three,
                     bus.pushbutton_two,  bus.pushbutton_one};

    // A level only flips after DEBOUNCE_CYCLES consecutive mismatching samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            levelPrev_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= rawBtn;
            sync2_q     <= sync1_q;
            levelPrev_q <= level_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] != level_q[i]) begin
                    if (cnt_q[i] == CNT_MAX) begin
                        level_q[i] <= ~level_q[i];
                        cnt_q[i]   <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 8'd1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    assign press    = level_q & ~levelPrev_q;
    assign anyPress = |press;

    always_comb begin
        pressOp = 2'b11;
        if (press[0]) begin
            pressOp = 2'b00;
        end else if (press[1]) begin
            pressOp = 2'b01;
        end else if (press[2]) begin
            pressOp = 2'b10;
        end
    end

    // Carry and borrow fall off naturally at WIDTH bits.
    always_comb begin
        result_d = '0;
        case (capOp_q)
            2'b00:   result_d = capA_q + capB_q;
            2'b01:   result_d = capA_q - capB_q;
            2'b10:   result_d = capA_q & capB_q;
            default: result_d = capA_q | capB_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            capA_q   <= '0;
            capB_q   <= '0;
            capOp_q  <= 2'b00;
            result_q <= '0;
            opCode_q <= 2'b00;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (anyPress) begin
                        capA_q  <= bus.A;
                        capB_q  <= bus.B;
                        capOp_q <= pressOp;
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    result_q <= result_d;
                    opCode_q <= capOp_q;
                    valid_q  <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    // Presses here are dropped; wait for every button to be released.
                    if (level_q == 4'b0000) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.result       = result_q;
    assign bus.op_code      = opCode_q;
    assign bus.result_valid = valid_q;
    assign bus.busy         = busy_q;

endmodule

// File: doc/pushbutton_alu_responder.md
Name: pushbutton_alu_responder

Overview:
- Registered responder for the four-button operand/operation interface: buttons one..four select an operation on 4-bit operands A and B.
- Synchronizes and debounces each pushbutton and detects press events.
- Captures A/B on an accepted press, computes the selected operation and holds the result with a valid flag.
- Sits between the board pushbuttons/switches and the result LEDs; the bench drives it as the initiator.

Parameters:
- WIDTH, 4, operand and result width in bits.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a level change; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- pushbutton_one  input  1  raw button, op ADD.
- pushbutton_two  input  1  raw button, op SUB.
- pushbutton_three  input  1  raw button, op AND.
- pushbutton_four  input  1  raw button, op OR.
- A  input  WIDTH  operand A (switches, asynchronous to clk; sampled only at capture).
- B  input  WIDTH  operand B.
- result  output  WIDTH  registered result of last completed operation.
- op_code  output  2  op of last capture: 00 ADD, 01 SUB, 10 AND, 11 OR.
- result_valid  output  1  high while in DONE.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, immediate): result=0, op_code=00, result_valid=0, busy=0; all synchronizer flops, debounced levels and counters=0; state=IDLE; captured A/B=0.
- Per button: 2-flop synchronizer (sync1, sync2).
  - Debounce counter increments each cycle sync2 != debounced level and clears when they match.
  - When the counter has reached DEBOUNCE_CYCLES-1 and the mismatch persists, the debounced level flips at the next edge and the counter clears.
  - Press event = debounced level high this cycle and low the previous cycle (one-cycle pulse).
- Glitch rule: a raw pulse whose synchronized high lasts fewer than DEBOUNCE_CYCLES cycles produces no press event.
- Priority: simultaneous press events resolve one > two > three > four; lower-priority events in that cycle are discarded.
- FSM (3 states):
  - IDLE: on any press event, register A, B and op; go EXEC. Otherwise stay.
  - EXEC (exactly 1 cycle): write result from captured operands; go DONE.
  - DONE: result_valid=1. Go IDLE when all four debounced levels are 0.
  - Press events arriving in EXEC or DONE are ignored, not queued.
- Arithmetic, modulo 2^WIDTH with carry/borrow discarded:
  - ADD = A+B.
  - SUB = A-B (two's complement wrap).
  - AND = A&B, OR = A|B (bitwise).
- Latency: let edge k be the first edge at which sync1 samples raw=1.
  - Debounced level rises at edge k+1+DEBOUNCE_CYCLES.
  - Capture at edge k+2+DEBOUNCE_CYCLES.
  - result, op_code and result_valid update at edge k+3+DEBOUNCE_CYCLES (k+7 at default).
- Operand stability: A/B changes after the capture edge do not affect the pending or held result.
- result and op_code hold their values until the next EXEC; they are not cleared when returning to IDLE.
- result_valid falls on the edge where DONE -> IDLE.
- Button held through reset deassertion: treated as a fresh press; the debounced level rises after the full debounce latency.
- Reset asserted mid-debounce or mid-EXEC: the operation is abandoned and no result is produced.

Test Plan:
- ADD: A=0011, B=0001, pulse pushbutton_one high for 10 cycles -> at edge k+7 result=0100, op_code=00, result_valid=1. After release + debounce, result_valid=0 and result stays 0100.
- SUB wrap: A=0001, B=0011, press two -> result=1110, op_code=01. ADD overflow: A=1111, B=0001, press one -> result=0000.
- Priority/logic ops: A=1100, B=1010, press one and four in the same cycle -> result=0110 (ADD), op_code=00. Then three alone -> 1000; four alone -> 1110.
- Debounce: raw pushbutton_two high for 3 synchronized cycles (DEBOUNCE_CYCLES=4) -> no busy, result unchanged. Bounce 1-0-1 within 2 cycles then hold -> exactly one operation.
- Ignore while busy: press one, change A to 0000 after capture, then press three during DONE -> result equals the original ADD of captured operands. No second operation until all buttons are released and a new press occurs.
- Reset mid-operation: assert reset at edge k+4 of an ADD press -> outputs immediately 0, state IDLE. Button still held after reset release -> new result at k'+7 counted from the first post-reset sample edge k'.
